// File: rtl/alu_sched.sv
// Two-requester front end for a shared multi-cycle ALU: round-robin grant,
// registered operand drive, fixed-latency capture and a held response.
module alu_sched #(
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic       req1_valid,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [3:0] req0_op,
   input  logic [3:0] req1_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_opcode,
   input  logic [7:0] alu_out,
   input  logic [4:0] alu_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_out,
   output logic [4:0] rsp_flags,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       last_grant;
   logic       grant;
   logic       accept;

   // On a tie the requester that was not served last wins; otherwise the only
   // valid one. With nobody valid, requester 0 is offered by default.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
   end

   assign accept = (state == IDLE) && (grant ? req1_valid : req0_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)     state_nxt = EXEC;
         EXEC:    if (cnt == '0)  state_nxt = RESP;
         RESP:    if (rsp_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = (state == IDLE) && !grant;
      req1_ready = (state == IDLE) &&  grant;
      rsp_valid  = (state == RESP);
      busy       = (state != IDLE);
   end

   // The ALU sees only these registers, so operand changes on the request
   // ports between accepts never reach it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         last_grant <= 1'b1;
         rsp_id     <= 1'b0;
         rsp_out    <= '0;
         rsp_flags  <= '0;
      end else begin
         if (accept) begin
            alu_a      <= grant ? req1_a  : req0_a;
            alu_b      <= grant ? req1_b  : req0_b;
            alu_opcode <= grant ? req1_op : req0_op;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= CNT_LOAD;
         end else if (state == EXEC) begin
            if (cnt == '0) begin
               rsp_out   <= alu_out;
               rsp_flags <= alu_flags;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: two instances (ALU_LAT 1 and 4) share one
// random request stream; each has its own ALU model, predictor and monitor.
module tb_alu_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       r0v, r1v, rsp_rdy;
   logic [7:0] r0a, r0b, r1a, r1b;
   logic [3:0] r0op, r1op;
   int         chk = 0;
   int         err = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU: {flags[4:0], out[7:0]}
   function automatic logic [12:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
      logic [8:0] r;
      case (op)
         4'd0:    r = {1'b0, a} + {1'b0, b};
         4'd1:    r = {1'b0, a} - {1'b0, b};
         4'd2:    r = {1'b0, a & b};
         4'd3:    r = {1'b0, a | b};
         4'd4:    r = {1'b0, a ^ b};
         4'd5:    r = {a, 1'b0};
         4'd6:    r = {2'b0, a[7:1]};
         4'd7:    r = {1'b0, ~a};
         4'd8:    r = {1'b0, b};
         4'd9:    r = {1'b0, 8'(a * b)};
         4'd10:   r = {1'b0, a} + 9'd1;
         4'd11:   r = {1'b0, b} - 9'd1;
         4'd12:   r = {1'b0, a[3:0], b[7:4]};
         4'd13:   r = {1'b0, (a > b) ? a : b};
         4'd14:   r = {1'b0, (a < b) ? a : b};
         default: r = (a == b) ? 9'd1 : 9'd2;
      endcase
      return {(r[7:0] == 8'd0), r[7], r[8], ^r[7:0], op[0], r[7:0]};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : 4;

      logic        r0rdy, r1rdy, rv, rid, bsy;
      logic [7:0]  alu_a, alu_b, alu_out, rout;
      logic [3:0]  alu_op;
      logic [4:0]  alu_flags, rflags;
      logic [12:0] alu_res;

      assign alu_res   = alu_fn(alu_a, alu_b, alu_op);
      assign alu_out   = alu_res[7:0];
      assign alu_flags = alu_res[12:8];

      alu_sched #(.ALU_LAT(LAT)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .req0_valid(r0v), .req1_valid(r1v),
         .req0_ready(r0rdy), .req1_ready(r1rdy),
         .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
         .req0_op(r0op), .req1_op(r1op),
         .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_op),
         .alu_out(alu_out), .alu_flags(alu_flags),
         .rsp_valid(rv), .rsp_ready(rsp_rdy), .rsp_id(rid),
         .rsp_out(rout), .rsp_flags(rflags), .busy(bsy)
      );

      logic [13:0] sb[$];        // {id, flags, out} of the one op in flight
      logic        m_last = 1'b1;
      logic [7:0]  m_a = '0, m_b = '0;
      logic [3:0]  m_op = '0;
      int          m_due = 0;    // cycle count at which the response must show
      int          n_rsp = 0;

      // Predictor: who may be accepted, what the ALU must see, what comes back.
      always @(negedge clk) begin
         bit idle, a0, a1, e0, e1;
         if (!rst_n) begin
            sb.delete();
            m_last = 1'b1;
            m_a = '0; m_b = '0; m_op = '0;
         end else begin
            idle = (sb.size() == 0);
            a0 = r0v && r0rdy;
            a1 = r1v && r1rdy;
            e0 = idle && r0v && (!r1v || m_last);
            e1 = idle && r1v && (!r0v || !m_last);
            check($sformatf("i%0d.accept0", g), 32'(a0), 32'(e0));
            check($sformatf("i%0d.accept1", g), 32'(a1), 32'(e1));
            check($sformatf("i%0d.both_ready", g), 32'(r0rdy && r1rdy), 32'd0);
            if (!idle)
               check($sformatf("i%0d.ready_busy", g), 32'(r0rdy || r1rdy), 32'd0);
            check($sformatf("i%0d.busy", g), 32'(bsy), 32'(!idle));
            check($sformatf("i%0d.alu_regs", g), {12'd0, alu_a, alu_b, alu_op},
                  {12'd0, m_a, m_b, m_op});
            if (e0 || e1) begin
               m_a    = e1 ? r1a  : r0a;
               m_b    = e1 ? r1b  : r0b;
               m_op   = e1 ? r1op : r0op;
               m_last = e1;
               m_due  = cyc + 1 + LAT;
               sb.push_back({e1, alu_fn(m_a, m_b, m_op)});
            end
         end
      end

      // Monitor: response timing and content against the scoreboard head.
      always begin
         bit due;
         @(negedge clk);
         #1;
         if (rst_n) begin
            due = (sb.size() != 0) && (cyc >= m_due);
            check($sformatf("i%0d.rsp_valid", g), 32'(rv), 32'(due));
            if (rv && sb.size() != 0) begin
               check($sformatf("i%0d.rsp", g), {18'd0, rid, rflags, rout}, {18'd0, sb[0]});
               if (rsp_rdy) begin
                  void'(sb.pop_front());
                  n_rsp++;
               end
            end
         end
      end

      // Reset must clear outputs immediately, not at the next edge.
      always @(negedge rst_n) begin
         #1;
         if (!rst_n) begin
            check($sformatf("i%0d.rst_alu", g), {12'd0, alu_a, alu_b, alu_op}, 32'd0);
            check($sformatf("i%0d.rst_rsp", g), {16'd0, rv, rid, rout, rflags, bsy}, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req();
      r0a = 8'($urandom); r0b = 8'($urandom); r0op = 4'($urandom);
      r1a = 8'($urandom); r1b = 8'($urandom); r1op = 4'($urandom);
   endtask

   initial begin
      r0v = 0; r1v = 0; rsp_rdy = 1;
      r0a = 0; r0b = 8'd255; r0op = 0; r1a = 0; r1b = 0; r1op = 0;
      repeat (3) step();
      r0v = 1;
      rst_n = 1;
      repeat (10) step();

      // both requesters continuously valid: grants must alternate
      r1v = 1;
      repeat (40) begin rand_req(); step(); end

      // back-pressure with inputs churning
      rsp_rdy = 0;
      repeat (15) begin rand_req(); step(); end
      rsp_rdy = 1;

      // opcode sweep on requester 0 only
      r1v = 0; r0a = 0; r0b = 8'd255;
      for (int op = 0; op < 16; op++) begin
         r0op = 4'(op);
         repeat (8) step();
      end

      // random traffic with dropped valids, stalls and reset pulses
      for (int i = 0; i < 400; i++) begin
         rand_req();
         r0v = ($urandom_range(0, 3) != 0);
         r1v = ($urandom_range(0, 3) != 0);
         rsp_rdy = ($urandom_range(0, 9) < 7);
         if (i % 60 == 33) begin
            #2 rst_n = 0;
            r0v = 1; r1v = 1;
            @(posedge clk);
            #1 rst_n = 1;
         end
         step();
      end

      r0v = 0; r1v = 0; rsp_rdy = 1;
      repeat (10) step();
      check("i0.progress", 32'(g_inst[0].n_rsp > 40), 32'd1);
      check("i1.progress", 32'(g_inst[1].n_rsp > 20), 32'd1);
      check("i0.drained", 32'(g_inst[0].sb.size()), 32'd0);
      check("i1.drained", 32'(g_inst[1].sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning cycles operands are held on the ALU before result capture; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  request pending from requester 0/1.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  request accepted on this edge if valid.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-007 SHALL have ports req0_op, req1_op  input  4 each  ALU opcode.
REQ-008 SHALL have ports alu_a, alu_b  output  8 each, and alu_opcode  output  4  driving the shared ALU.
REQ-009 SHALL have ports alu_out  input  8, and alu_flags  input  5  from the shared ALU.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1, rsp_out  output  8, rsp_flags  output  5.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-013 IDLE: grant = requester with valid; if both valid, grant = requester not granted last (round-robin); reqN_ready = (state==IDLE) && (grant==N), combinational; never both ready.
REQ-014 Accept edge (valid&&ready): latch a, b, op into alu_a/alu_b/alu_opcode registers, latch id, update last_grant, load counter with ALU_LAT-1, go EXEC.
REQ-015 alu_a/alu_b/alu_opcode SHALL come from registers only, stable from accept until next accept; no combinational path from req inputs.
REQ-016 EXEC: decrement counter each edge; on edge with counter==0, capture alu_out into rsp_out and alu_flags into rsp_flags, go RESP.
REQ-017 Latency: accept at edge T -> capture at edge T+ALU_LAT -> rsp_valid high from T+ALU_LAT.
REQ-018 RESP: rsp_valid=1; rsp_out/rsp_flags/rsp_id held stable until rsp_ready; on edge with rsp_ready high go IDLE, rsp_valid low next cycle.
REQ-019 Back-pressure: rsp_ready low holds RESP indefinitely; no request accepted meanwhile.
REQ-020 Max throughput: one operation per ALU_LAT+2 cycles (next accept earliest at edge T+ALU_LAT+2).
REQ-021 Request inputs changing while not ready SHALL have no effect; valid dropped before accept SHALL not be recorded.
REQ-022 Arbitration SHALL be fair: with both requesters continuously valid, grants alternate 0,1,0,1...

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, alu_a/alu_b 0, alu_opcode 0, rsp_out 0, rsp_flags 0, rsp_id 0, rsp_valid 0, busy 0, last_grant 1 (requester 0 wins first tie).
REQ-024 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation with no response emitted; first accept allowed on first edge after rst_n deasserts.

Verification
REQ-025 Reset, then req0_valid=1 a=0 b=255 op=0, rsp_ready=1, ALU_LAT=1 -> req0_ready high at edge 0, rsp_valid high after edge 1 with rsp_id=0, rsp_out/rsp_flags equal ALU model for (0,255,0), rsp_valid low after edge 2.
REQ-026 Both valid continuously for 4 ops, opcodes 0..3 -> rsp_id sequence 0,1,0,1; each result matches its own requester's operands.
REQ-027 rsp_ready held low 10 cycles in RESP -> rsp_valid stays 1, rsp_out/rsp_flags/rsp_id unchanged, req0_ready/req1_ready stay 0, alu_* unchanged.
REQ-028 ALU_LAT=4, sweep op 0..15 with a=0 b=255 -> each rsp_valid exactly 4 cycles after accept; alu_* stable throughout EXEC.
REQ-029 rst_n pulsed low during EXEC -> outputs return to reset values asynchronously, no rsp_valid pulse, next request served normally with req0 winning a tie.
